// File: rtl/ctrl_master_pkg.sv
// Shared constants for the control-register sequencer: register map, control
// words, run modes and FSM encodings.
package ctrl_master_pkg;

  localparam int MODE_LEN = 1;
  localparam logic [MODE_LEN-1:0] TRAIN   = 1'b1;
  localparam logic [MODE_LEN-1:0] FORWARD = 1'b0;

  localparam logic [3:0] REG_CTRL = 4'h0;
  localparam logic [3:0] REG_MODE = 4'h4;
  localparam logic [3:0] REG_STAT = 4'h8;

  // Control word bits are {next, set, run, rst_n}
  localparam logic [3:0] CTRL_NEXT = 4'b1001;
  localparam logic [3:0] CTRL_SET  = 4'b0101;
  localparam logic [3:0] CTRL_RUN  = 4'b0011;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_W_NEXT   = 4'd1,
    ST_W_MODE   = 4'd2,
    ST_W_SET    = 4'd3,
    ST_WAIT_SET = 4'd4,
    ST_W_RUN    = 4'd5,
    ST_R_POLL   = 4'd6,
    ST_GAP      = 4'd7,
    ST_DONE     = 4'd8
  } seq_state_e;

  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_ADDR = 2'd1,
    ENG_RESP = 2'd2
  } eng_state_e;

  function automatic logic resp_err(input logic [1:0] resp);
    return (resp != 2'b00);
  endfunction

endpackage

// File: rtl/ctrl_master_if.sv
// AXI4-Lite bundle between the sequencer's master engine and the accelerator slave port.
interface ctrl_master_if #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
);
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [2:0]                    M_AXI_AWPROT;
  logic                          M_AXI_AWVALID;
  logic                          M_AXI_AWREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [3:0]                    M_AXI_WSTRB;
  logic                          M_AXI_WVALID;
  logic                          M_AXI_WREADY;
  logic [1:0]                    M_AXI_BRESP;
  logic                          M_AXI_BVALID;
  logic                          M_AXI_BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]                    M_AXI_ARPROT;
  logic                          M_AXI_ARVALID;
  logic                          M_AXI_ARREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]                    M_AXI_RRESP;
  logic                          M_AXI_RVALID;
  logic                          M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, input M_AXI_ARREADY,
    input M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, output M_AXI_AWREADY,
    input M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/ctrl_master_axil_master_if.sv
// Single-transaction AXI4-Lite master engine: one read or write per req,
// ack pulses the cycle after the B or R handshake with the captured response.
module axil_master_if
  import ctrl_master_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          req,
  input  logic                          we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] wdata,
  output logic                          ack,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rdata,
  output logic [1:0]                    resp,
  ctrl_master_if.master                 axi
);

  eng_state_e                    eng_r;
  logic                          we_r;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_r;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_r;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_r;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_r;
  logic [1:0]                    resp_r;
  logic                          awvalid_r;
  logic                          wvalid_r;
  logic                          bready_r;
  logic                          arvalid_r;
  logic                          rready_r;
  logic                          ack_r;
  logic                          aw_clear_s;
  logic                          w_clear_s;

  // A channel counts as finished if already handshaken or handshaking this cycle
  assign aw_clear_s = !awvalid_r || axi.M_AXI_AWREADY;
  assign w_clear_s  = !wvalid_r  || axi.M_AXI_WREADY;

  // Transaction engine: issue, hold VALIDs until READY, then collect the response
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      eng_r     <= ENG_IDLE;
      we_r      <= 1'b0;
      awaddr_r  <= '0;
      araddr_r  <= '0;
      wdata_r   <= '0;
      rdata_r   <= '0;
      resp_r    <= 2'b00;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      ack_r     <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      case (eng_r)
        ENG_IDLE: begin
          if (req) begin
            we_r  <= we;
            eng_r <= ENG_ADDR;
            if (we) begin
              awaddr_r  <= addr;
              wdata_r   <= wdata;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
            end else begin
              araddr_r  <= addr;
              arvalid_r <= 1'b1;
            end
          end
        end
        ENG_ADDR: begin
          if (we_r) begin
            if (awvalid_r && axi.M_AXI_AWREADY) awvalid_r <= 1'b0;
            if (wvalid_r && axi.M_AXI_WREADY) wvalid_r <= 1'b0;
            if (aw_clear_s && w_clear_s) begin
              bready_r <= 1'b1;
              eng_r    <= ENG_RESP;
            end
          end else if (axi.M_AXI_ARREADY) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            eng_r     <= ENG_RESP;
          end
        end
        ENG_RESP: begin
          if (we_r) begin
            if (axi.M_AXI_BVALID) begin
              bready_r <= 1'b0;
              resp_r   <= axi.M_AXI_BRESP;
              ack_r    <= 1'b1;
              eng_r    <= ENG_IDLE;
            end
          end else if (axi.M_AXI_RVALID) begin
            rready_r <= 1'b0;
            rdata_r  <= axi.M_AXI_RDATA;
            resp_r   <= axi.M_AXI_RRESP;
            ack_r    <= 1'b1;
            eng_r    <= ENG_IDLE;
          end
        end
        default: eng_r <= ENG_IDLE;
      endcase
    end
  end

  assign axi.M_AXI_AWADDR  = awaddr_r;
  assign axi.M_AXI_AWPROT  = 3'b000;
  assign axi.M_AXI_AWVALID = awvalid_r;
  assign axi.M_AXI_WDATA   = wdata_r;
  assign axi.M_AXI_WSTRB   = 4'b1111;
  assign axi.M_AXI_WVALID  = wvalid_r;
  assign axi.M_AXI_BREADY  = bready_r;
  assign axi.M_AXI_ARADDR  = araddr_r;
  assign axi.M_AXI_ARPROT  = 3'b000;
  assign axi.M_AXI_ARVALID = arvalid_r;
  assign axi.M_AXI_RREADY  = rready_r;
  assign ack   = ack_r;
  assign rdata = rdata_r;
  assign resp  = resp_r;

endmodule

// File: rtl/ctrl_master.sv
// Hardware sequencer for the accelerator control registers: next, mode, set,
// wait, run, then poll the finish flag until it reads 1.
module ctrl_master
  import ctrl_master_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int SET_WAIT           = 15,
  parameter int POLL_GAP           = 4
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                start,
  input  logic [MODE_LEN-1:0] mode,
  output logic                busy,
  output logic                done,
  output logic                err,
  ctrl_master_if.master       axi
);

  seq_state_e                    state_r;
  logic [15:0]                   cnt_r;
  logic [MODE_LEN-1:0]           mode_r;
  logic                          busy_r;
  logic                          done_r;
  logic                          err_r;
  logic                          req_s;
  logic                          we_s;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_s;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_s;
  logic                          ack_s;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_s;
  logic [1:0]                    resp_s;
  logic                          unused_rdata_s;

  assign unused_rdata_s = ^rdata_s[C_M_AXI_DATA_WIDTH-1:1];

  // Next transaction is launched in the same cycle the previous one acks, keeping each access at three cycles
  always_comb begin
    req_s   = 1'b0;
    we_s    = 1'b1;
    addr_s  = '0;
    wdata_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          req_s   = 1'b1;
          addr_s  = C_M_AXI_ADDR_WIDTH'(REG_CTRL);
          wdata_s = C_M_AXI_DATA_WIDTH'(CTRL_NEXT);
        end else begin
          req_s = 1'b0;
        end
      end
      ST_W_NEXT: begin
        req_s   = ack_s;
        addr_s  = C_M_AXI_ADDR_WIDTH'(REG_MODE);
        wdata_s = C_M_AXI_DATA_WIDTH'(mode_r);
      end
      ST_W_MODE: begin
        req_s   = ack_s;
        addr_s  = C_M_AXI_ADDR_WIDTH'(REG_CTRL);
        wdata_s = C_M_AXI_DATA_WIDTH'(CTRL_SET);
      end
      ST_WAIT_SET: begin
        req_s   = (cnt_r == 16'(SET_WAIT - 1));
        addr_s  = C_M_AXI_ADDR_WIDTH'(REG_CTRL);
        wdata_s = C_M_AXI_DATA_WIDTH'(CTRL_RUN);
      end
      ST_W_RUN: begin
        req_s  = ack_s;
        we_s   = 1'b0;
        addr_s = C_M_AXI_ADDR_WIDTH'(REG_STAT);
      end
      ST_GAP: begin
        req_s  = (cnt_r == 16'(POLL_GAP - 1));
        we_s   = 1'b0;
        addr_s = C_M_AXI_ADDR_WIDTH'(REG_STAT);
      end
      default: begin
        req_s = 1'b0;
      end
    endcase
  end

  // Sequence FSM with registered status outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r <= ST_IDLE;
      cnt_r   <= 16'd0;
      mode_r  <= FORWARD;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (ack_s && resp_err(resp_s)) err_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mode_r  <= mode;
            busy_r  <= 1'b1;
            err_r   <= 1'b0;
            state_r <= ST_W_NEXT;
          end
        end
        ST_W_NEXT: if (ack_s) state_r <= ST_W_MODE;
        ST_W_MODE: if (ack_s) state_r <= ST_W_SET;
        ST_W_SET: begin
          if (ack_s) begin
            cnt_r   <= 16'd0;
            state_r <= ST_WAIT_SET;
          end
        end
        ST_WAIT_SET: begin
          cnt_r <= cnt_r + 16'd1;
          if (cnt_r == 16'(SET_WAIT - 1)) state_r <= ST_W_RUN;
        end
        ST_W_RUN: if (ack_s) state_r <= ST_R_POLL;
        ST_R_POLL: begin
          if (ack_s) begin
            cnt_r <= 16'd0;
            if (rdata_s[0]) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          cnt_r <= cnt_r + 16'd1;
          if (cnt_r == 16'(POLL_GAP - 1)) state_r <= ST_R_POLL;
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  axil_master_if #(
    .C_M_AXI_DATA_WIDTH(C_M_AXI_DATA_WIDTH),
    .C_M_AXI_ADDR_WIDTH(C_M_AXI_ADDR_WIDTH)
  ) u_eng (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .req     (req_s),
    .we      (we_s),
    .addr    (addr_s),
    .wdata   (wdata_s),
    .ack     (ack_s),
    .rdata   (rdata_s),
    .resp    (resp_s),
    .axi     (axi)
  );

  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_ctrl_master.sv
// Directed bench for ctrl_master against a small AXI4-Lite slave model with
// programmable READY delays, error injection and finish-flag timing.
module tb_ctrl_master;
  import ctrl_master_pkg::*;

  logic                ACLK = 1'b0;
  logic                ARESETN = 1'b0;
  logic                start = 1'b0;
  logic [MODE_LEN-1:0] mode = FORWARD;
  logic                busy, done, err;

  ctrl_master_if #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(4)) axi ();

  ctrl_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(4), .SET_WAIT(15), .POLL_GAP(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .mode(mode),
    .busy(busy), .done(done), .err(err), .axi(axi)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration, driven by the stimulus process
  logic [3:0] aw_dly = 4'd0;
  logic [3:0] w_dly  = 4'd0;
  int         bad_idx = -1;
  int         fin_at  = 1;
  logic       log_clr = 1'b0;

  // Slave state and logs
  logic [3:0]  aw_cnt, w_cnt;
  logic        aw_got, w_got, s_bvalid, s_rvalid;
  logic [1:0]  s_bresp;
  logic [31:0] s_rdata;
  logic [3:0]  cur_addr;
  logic [31:0] cur_data;
  logic        awv_p, awr_p, wv_p, wr_p;
  logic [3:0]  awaddr_p;
  logic [31:0] wdata_p;
  int cyc = 0;
  int n_wr, n_rd, rd_bad, viol, done_cnt, start_cyc, done_cyc;
  logic [3:0]  wr_addr [16];
  logic [31:0] wr_data [16];
  int aw_cyc [16], b_cyc [16], aw_hs_cyc [16], w_hs_cyc [16], ar_cyc [16], r_cyc [16];

  logic aw_hs, w_hs, aw_now, w_now;
  assign axi.M_AXI_AWREADY = (aw_cnt >= aw_dly);
  assign axi.M_AXI_WREADY  = (w_cnt >= w_dly);
  assign axi.M_AXI_BVALID  = s_bvalid;
  assign axi.M_AXI_BRESP   = s_bresp;
  assign axi.M_AXI_ARREADY = 1'b1;
  assign axi.M_AXI_RVALID  = s_rvalid;
  assign axi.M_AXI_RDATA   = s_rdata;
  assign axi.M_AXI_RRESP   = 2'b00;
  assign aw_hs  = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
  assign w_hs   = axi.M_AXI_WVALID && axi.M_AXI_WREADY;
  assign aw_now = aw_got || aw_hs;
  assign w_now  = w_got || w_hs;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Slave model plus protocol monitor and transaction log
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt <= 4'd0; w_cnt <= 4'd0; aw_got <= 1'b0; w_got <= 1'b0;
      s_bvalid <= 1'b0; s_bresp <= 2'b00; s_rvalid <= 1'b0; s_rdata <= 32'd0;
      awv_p <= 1'b0; awr_p <= 1'b0; wv_p <= 1'b0; wr_p <= 1'b0;
    end else if (log_clr) begin
      n_wr <= 0; n_rd <= 0; rd_bad <= 0; viol <= 0; done_cnt <= 0;
      start_cyc <= 0; done_cyc <= 0;
    end else begin
      if (aw_hs) begin
        aw_cnt <= 4'd0; aw_got <= 1'b1; cur_addr <= axi.M_AXI_AWADDR; aw_hs_cyc[n_wr] <= cyc;
      end else if (axi.M_AXI_AWVALID) aw_cnt <= aw_cnt + 4'd1;
      if (w_hs) begin
        w_cnt <= 4'd0; w_got <= 1'b1; cur_data <= axi.M_AXI_WDATA; w_hs_cyc[n_wr] <= cyc;
      end else if (axi.M_AXI_WVALID) w_cnt <= w_cnt + 4'd1;
      if (aw_now && w_now && !s_bvalid) begin
        s_bvalid <= 1'b1;
        s_bresp  <= (n_wr == bad_idx) ? 2'b10 : 2'b00;
        wr_addr[n_wr] <= aw_hs ? axi.M_AXI_AWADDR : cur_addr;
        wr_data[n_wr] <= w_hs ? axi.M_AXI_WDATA : cur_data;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (s_bvalid && axi.M_AXI_BREADY) begin
        s_bvalid <= 1'b0; b_cyc[n_wr] <= cyc; n_wr <= n_wr + 1;
      end
      if (axi.M_AXI_AWVALID && !awv_p) aw_cyc[n_wr] <= cyc;
      if (axi.M_AXI_ARVALID) begin
        s_rvalid <= 1'b1;
        s_rdata  <= (n_rd + 1 >= fin_at) ? 32'd1 : 32'd0;
        ar_cyc[n_rd] <= cyc;
        if (axi.M_AXI_ARADDR != 4'h8) rd_bad <= rd_bad + 1;
      end
      if (s_rvalid && axi.M_AXI_RREADY) begin
        s_rvalid <= 1'b0; r_cyc[n_rd] <= cyc; n_rd <= n_rd + 1;
      end
      if (awv_p && !awr_p && (!axi.M_AXI_AWVALID || axi.M_AXI_AWADDR != awaddr_p)) viol <= viol + 1;
      if (wv_p && !wr_p && (!axi.M_AXI_WVALID || axi.M_AXI_WDATA != wdata_p)) viol <= viol + 1;
      awv_p <= axi.M_AXI_AWVALID; awr_p <= axi.M_AXI_AWREADY; awaddr_p <= axi.M_AXI_AWADDR;
      wv_p  <= axi.M_AXI_WVALID;  wr_p  <= axi.M_AXI_WREADY;  wdata_p  <= axi.M_AXI_WDATA;
      if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (start && !busy) start_cyc <= cyc;
    end
  end

  task automatic clear_logs();
    @(negedge ACLK); log_clr = 1'b1;
    @(negedge ACLK); log_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [MODE_LEN-1:0] m);
    @(negedge ACLK); start = 1'b1; mode = m;
    @(negedge ACLK); start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc && done_cnt == 0; i++) @(negedge ACLK);
    repeat (4) @(negedge ACLK);
  endtask

  task automatic run_batch(input logic [MODE_LEN-1:0] m, input logic [3:0] awd, input logic [3:0] wd,
                           input int bad, input int fin);
    aw_dly = awd; w_dly = wd; bad_idx = bad; fin_at = fin;
    clear_logs();
    pulse_start(m);
    wait_done(400);
  endtask

  initial begin
    #1;
    check("rst_awvalid", {31'd0, axi.M_AXI_AWVALID}, 32'd0);
    check("rst_arvalid", {31'd0, axi.M_AXI_ARVALID}, 32'd0);
    check("rst_status", {29'd0, busy, done, err}, 32'd0);
    check("rst_awaddr", {28'd0, axi.M_AXI_AWADDR}, 32'd0);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;

    // Zero-wait slave, TRAIN, finish on third read
    run_batch(TRAIN, 4'd0, 4'd0, -1, 3);
    check("zw_nwr", n_wr, 32'd4);
    check("zw_a0", {28'd0, wr_addr[0]}, 32'h0); check("zw_d0", wr_data[0], 32'h9);
    check("zw_a1", {28'd0, wr_addr[1]}, 32'h4); check("zw_d1", wr_data[1], 32'h1);
    check("zw_a2", {28'd0, wr_addr[2]}, 32'h0); check("zw_d2", wr_data[2], 32'h5);
    check("zw_a3", {28'd0, wr_addr[3]}, 32'h0); check("zw_d3", wr_data[3], 32'h3);
    check("zw_nrd", n_rd, 32'd3);
    check("zw_rdaddr", rd_bad, 32'd0);
    check("zw_done", done_cnt, 32'd1);
    check("zw_err", {31'd0, err}, 32'd0);
    check("zw_busy", {31'd0, busy}, 32'd0);
    check("zw_first_aw", aw_cyc[0] - start_cyc, 32'd1);
    check("zw_latency", done_cyc - start_cyc, 32'd45);
    check("zw_set_wait", aw_cyc[3] - b_cyc[2], 32'd17);
    check("zw_poll_gap", ar_cyc[2] - r_cyc[1], 32'd6);
    check("zw_wstrb", {28'd0, axi.M_AXI_WSTRB}, 32'hF);

    // Delayed AWREADY/WREADY, FORWARD, finish on first read
    run_batch(FORWARD, 4'd2, 4'd5, -1, 1);
    check("dl_nwr", n_wr, 32'd4);
    check("dl_stable", viol, 32'd0);
    check("dl_aw_hs", aw_hs_cyc[0] - aw_cyc[0], 32'd2);
    check("dl_w_hs", w_hs_cyc[0] - aw_cyc[0], 32'd5);
    check("dl_d1", wr_data[1], 32'h0);
    check("dl_d3", wr_data[3], 32'h3);
    check("dl_done", done_cnt, 32'd1);

    // Error on mode write does not abort
    run_batch(TRAIN, 4'd0, 4'd0, 1, 2);
    check("er_err", {31'd0, err}, 32'd1);
    check("er_nwr", n_wr, 32'd4);
    check("er_nrd", n_rd, 32'd2);
    check("er_done", done_cnt, 32'd1);
    aw_dly = 4'd0; w_dly = 4'd0; bad_idx = -1; fin_at = 1;
    clear_logs();
    pulse_start(TRAIN);
    check("er_clear", {31'd0, err}, 32'd0);
    wait_done(400);
    check("er_clear_done", done_cnt, 32'd1);

    // Reset while a poll read is outstanding
    fin_at = 5;
    clear_logs();
    pulse_start(FORWARD);
    for (int i = 0; i < 200 && !axi.M_AXI_ARVALID; i++) @(negedge ACLK);
    check("rs_arvalid_seen", {31'd0, axi.M_AXI_ARVALID}, 32'd1);
    ARESETN = 1'b0;
    #1;
    check("rs_arvalid", {31'd0, axi.M_AXI_ARVALID}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd0);
    @(negedge ACLK); ARESETN = 1'b1;
    run_batch(TRAIN, 4'd0, 4'd0, -1, 1);
    check("rs_nwr", n_wr, 32'd4);
    check("rs_d0", wr_data[0], 32'h9);
    check("rs_d3", wr_data[3], 32'h3);
    check("rs_done", done_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_master.md
# ctrl_master

AXI4-Lite master that sequences the accelerator's control register protocol in hardware: it loads the next batch, programs the run mode, issues set then run, and polls the finish flag. It sits on the AXI4-Lite slave port of `top` and replaces software/bench register writes, so an on-chip controller needs only a `start` pulse per batch and a mode value.

## Interface
Parameters:
- `C_M_AXI_DATA_WIDTH`, 32: AXI-Lite data width.
- `C_M_AXI_ADDR_WIDTH`, 4: AXI-Lite address width.
- `SET_WAIT`, 15: idle cycles between the set write's B handshake and the run write.
- `POLL_GAP`, 4: idle cycles between successive finish-flag reads.

Ports:
- `ACLK` in 1: clock. One clock; all logic on its rising edge.
- `ARESETN` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `mode` in `MODE_LEN`: run mode (`TRAIN`/`FORWARD`); captured on accepted `start`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse when the finish flag is read as 1.
- `err` out 1: sticky; set on any BRESP/RRESP ≠ 0; cleared by the next accepted `start`.
- `M_AXI_AWADDR` out `C_M_AXI_ADDR_WIDTH`, `M_AXI_AWPROT` out 3 (always 0), `M_AXI_AWVALID` out 1, `M_AXI_AWREADY` in 1.
- `M_AXI_WDATA` out `C_M_AXI_DATA_WIDTH`, `M_AXI_WSTRB` out 4 (always 4'b1111), `M_AXI_WVALID` out 1, `M_AXI_WREADY` in 1.
- `M_AXI_BRESP` in 2, `M_AXI_BVALID` in 1, `M_AXI_BREADY` out 1.
- `M_AXI_ARADDR` out `C_M_AXI_ADDR_WIDTH`, `M_AXI_ARPROT` out 3 (always 0), `M_AXI_ARVALID` out 1, `M_AXI_ARREADY` in 1.
- `M_AXI_RDATA` in `C_M_AXI_DATA_WIDTH`, `M_AXI_RRESP` in 2, `M_AXI_RVALID` in 1, `M_AXI_RREADY` out 1.

## Operation
- Register map: slv_reg0 @0x0 = {next, set, run, rst_n} in bits [3:0]; slv_reg1 @0x4 = mode; slv_reg2 @0x8 bit0 = finish.
- FSM: IDLE → W_NEXT (reg0 ← 4'b1001) → W_MODE (reg1 ← mode) → W_SET (reg0 ← 4'b0101) → WAIT_SET (`SET_WAIT` cycles) → W_RUN (reg0 ← 4'b0011) → R_POLL (read reg2) → {GAP for `POLL_GAP` cycles → R_POLL if bit0 = 0 | DONE if bit0 = 1} → IDLE.
- DONE lasts one cycle: it asserts `done`, deasserts `busy`, and returns to IDLE. No write follows, so reg0 is left at 4'b0011.
- An error response does not abort the sequence. It only sets `err`.
- `start` while busy is ignored. There is no queueing.

## Timing
- Reset values: all VALID/READY outputs 0, addresses/WDATA 0, `busy` = `done` = `err` = 0, FSM in IDLE.
- Write transaction: AWVALID and WVALID rise in the same cycle. Each is held, with stable address/data, until its own READY is sampled high; the two may complete in different cycles. BREADY rises after both have handshaken and drops the cycle after BVALID&BREADY. The FSM advances on the B handshake.
- Read transaction: ARVALID is held until ARREADY. RREADY is asserted from the AR handshake until RVALID&RREADY. RDATA/RRESP are captured on that edge, and the FSM decision is made the next cycle.
- VALID never depends combinationally on READY. No outputs are combinational from AXI inputs.
- Latency with zero-wait slave: `start` → first AWVALID = 1 cycle. Minimum `start` → `done` = 4 writes × 3 cycles + `SET_WAIT` + (reads × 3 + gaps × `POLL_GAP`) + 1.
- `ARESETN` low mid-transaction: all VALIDs drop asynchronously, the FSM goes to IDLE, and `busy` clears. No resumption.
- AWREADY/WREADY already high when VALID rises: handshake completes in that cycle.

## Structure
- Shared package `consts_train.vh` gains: register offsets (`REG_CTRL`, `REG_MODE`, `REG_STAT`), control words (`CTRL_NEXT` = 4'b1001, `CTRL_SET` = 4'b0101, `CTRL_RUN` = 4'b0011), and FSM state encodings. It reuses existing `MODE_LEN`/`TRAIN`/`FORWARD`.
- Sub-module `axil_master_if`: single-transaction engine with req/we/addr/wdata in, ack/rdata/resp out. It owns all five AXI channels. `ctrl_master` holds only the sequence FSM and counters.

## Test plan
- Zero-wait AXI-Lite slave model, `start` with mode=`TRAIN`, finish=1 on 3rd read → writes observed in order 0x0/0x9, 0x4/TRAIN, 0x0/0x5, 0x0/0x3; exactly 3 reads of 0x8; one `done` pulse; `err` = 0.
- Slave with AWREADY delayed 2 cycles, WREADY delayed 5 → AWVALID/WVALID held with stable addr/data; each drops independently; no duplicate write.
- `SET_WAIT` = 15 → exactly 15 idle cycles between the set B handshake and the run AWVALID. `POLL_GAP` = 4 → 4 idle cycles between reads.
- Slave returns BRESP = 2'b10 on the mode write → `err` = 1, sequence completes, `done` pulses. Next `start` clears `err`.
- `ARESETN` pulled low while ARVALID = 1 → ARVALID and `busy` = 0 immediately. After release, a fresh `start` runs the full sequence.
- Connected to `top` with 4 batches streamed in (3×TRAIN, 1×FORWARD) → `done` per batch; `comp_q` matches the golden file for every batch.
